// File: rtl/dds_ctrl_pkg.sv
// Shared types and encodings for the DDS load sequencer and its per-word pulse timer.
package dds_ctrl_pkg;

    localparam logic [1:0] MODE_FREQ  = 2'b00;
    localparam logic [1:0] MODE_PHASE = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_SWEEP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    typedef enum logic {
        SEL_F,
        SEL_P
    } sel_t;

endpackage

// File: rtl/dds_load_pulse.sv
// Single-word SETUP/PULSE/RELEASE timer: registers the word, drives the bus and the
// selected load strobe, and flags the final RELEASE cycle on `last`.
module dds_load_pulse
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  sel_t                  sel,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] freq_phase,
    output logic                  load_f,
    output logic                  load_p,
    output logic                  last
);

    localparam int unsigned    MAX_CYC    = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int unsigned    CW         = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_CYCLES - 1);

    state_t                  phase_q, phase_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    sel_t                    sel_q, sel_d;
    logic                    lf_q, lf_d;
    logic                    lp_q, lp_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sel_d   = sel_q;
        lf_d    = lf_q;
        lp_d    = lp_q;
        if (abort) begin
            phase_d = ST_IDLE;
            cnt_d   = '0;
            lf_d    = 1'b0;
            lp_d    = 1'b0;
        end else if (start) begin
            phase_d = ST_SETUP;
            cnt_d   = HOLD_LAST;
            word_d  = word;
            sel_d   = sel;
            lf_d    = 1'b0;
            lp_d    = 1'b0;
        end else begin
            case (phase_q)
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        phase_d = ST_PULSE;
                        cnt_d   = PULSE_LAST;
                        lf_d    = (sel_q == SEL_F);
                        lp_d    = (sel_q == SEL_P);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        phase_d = ST_RELEASE;
                        cnt_d   = HOLD_LAST;
                        lf_d    = 1'b0;
                        lp_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == '0) begin
                        phase_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            sel_q   <= SEL_F;
            lf_q    <= 1'b0;
            lp_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            lf_q    <= lf_d;
            lp_q    <= lp_d;
        end
    end

    assign freq_phase = word_q;
    assign load_f     = lf_q;
    assign load_p     = lp_q;
    assign last       = (phase_q == ST_RELEASE) && (cnt_q == '0);

endmodule

// File: rtl/dds_load_sequencer.sv
// Command-driven DDS load sequencer: decodes commands into a word list and feeds each word
// to dds_load_pulse. Define DDS_SWEEP_EN to enable mode-11 frequency sweeps.
module dds_load_sequencer
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_mode,
    input  logic [DATA_WIDTH-1:0]  cmd_freq,
    input  logic [DATA_WIDTH-1:0]  cmd_phase,
    input  logic [DATA_WIDTH-1:0]  cmd_sweep_step,
    input  logic [COUNT_WIDTH-1:0] cmd_sweep_count,
    input  logic                   abort,
    output logic [DATA_WIDTH-1:0]  FreqPhase,
    output logic                   LoadF,
    output logic                   LoadP,
    output logic                   busy,
    output logic                   done
);

    // SETUP/PULSE/RELEASE are timed inside dds_load_pulse; here ST_SETUP marks a word in flight.
    state_t                  seq_q, seq_d;
    logic [DATA_WIDTH-1:0]   phase_word_q, phase_word_d;
    logic                    phase_pend_q, phase_pend_d;
`ifdef DDS_SWEEP_EN
    logic [DATA_WIDTH-1:0]   step_q, step_d;
    logic [COUNT_WIDTH-1:0]  remain_q, remain_d;
`else
    logic                    unused_sweep;
    assign unused_sweep = ^{cmd_sweep_step, cmd_sweep_count};
`endif

    logic                    start;
    sel_t                    start_sel;
    logic [DATA_WIDTH-1:0]   start_word;
    logic                    word_last;

    assign cmd_ready = (seq_q == ST_IDLE) & ~abort;
    assign busy      = (seq_q != ST_IDLE);
    assign done      = (seq_q == ST_DONE);

    always_comb begin
        seq_d        = seq_q;
        phase_word_d = phase_word_q;
        phase_pend_d = phase_pend_q;
`ifdef DDS_SWEEP_EN
        step_d       = step_q;
        remain_d     = remain_q;
`endif
        start        = 1'b0;
        start_sel    = SEL_F;
        start_word   = cmd_freq;
        if (abort) begin
            seq_d = ST_IDLE;
        end else begin
            case (seq_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        start        = 1'b1;
                        seq_d        = ST_SETUP;
                        phase_word_d = cmd_phase;
                        if (cmd_mode == MODE_PHASE) begin
                            start_sel  = SEL_P;
                            start_word = cmd_phase;
                        end
`ifdef DDS_SWEEP_EN
                        phase_pend_d = (cmd_mode == MODE_BOTH);
                        step_d       = cmd_sweep_step;
                        remain_d     = (cmd_mode == MODE_SWEEP) ? cmd_sweep_count : '0;
`else
                        phase_pend_d = (cmd_mode == MODE_BOTH) || (cmd_mode == MODE_SWEEP);
`endif
                    end
                end
                ST_SETUP: begin
                    if (word_last) begin
`ifdef DDS_SWEEP_EN
                        if (remain_q != '0) begin
                            start      = 1'b1;
                            start_word = FreqPhase + step_q;
                            remain_d   = remain_q - COUNT_WIDTH'(1);
                        end else
`endif
                        if (phase_pend_q) begin
                            start        = 1'b1;
                            start_sel    = SEL_P;
                            start_word   = phase_word_q;
                            phase_pend_d = 1'b0;
                        end else begin
                            seq_d = ST_DONE;
                        end
                    end
                end
                default: seq_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q        <= ST_IDLE;
            phase_word_q <= '0;
            phase_pend_q <= 1'b0;
`ifdef DDS_SWEEP_EN
            step_q       <= '0;
            remain_q     <= '0;
`endif
        end else begin
            seq_q        <= seq_d;
            phase_word_q <= phase_word_d;
            phase_pend_q <= phase_pend_d;
`ifdef DDS_SWEEP_EN
            step_q       <= step_d;
            remain_q     <= remain_d;
`endif
        end
    end

    dds_load_pulse #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulse (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (start_sel),
        .word      (start_word),
        .abort     (abort),
        .freq_phase(FreqPhase),
        .load_f    (LoadF),
        .load_p    (LoadP),
        .last      (word_last)
    );

endmodule

// File: tb/tb_dds_load_sequencer.sv
// Randomized self-checking bench for dds_load_sequencer against a word-list timing model.
module tb_dds_load_sequencer;

    localparam int unsigned DW    = 16;
    localparam int unsigned CWID  = 8;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned PULSE = 2;
    localparam int unsigned W     = 2 * HOLD + PULSE;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_mode;
    logic [DW-1:0]   cmd_freq;
    logic [DW-1:0]   cmd_phase;
    logic [DW-1:0]   cmd_sweep_step;
    logic [CWID-1:0] cmd_sweep_count;
    logic            abort;
    logic [DW-1:0]   FreqPhase;
    logic            LoadF;
    logic            LoadP;
    logic            busy;
    logic            done;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [DW-1:0]   last_fp;

    always #5 clk = ~clk;

    dds_load_sequencer #(
        .DATA_WIDTH  (DW),
        .HOLD_CYCLES (HOLD),
        .PULSE_CYCLES(PULSE),
        .COUNT_WIDTH (CWID)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_freq       (cmd_freq),
        .cmd_phase      (cmd_phase),
        .cmd_sweep_step (cmd_sweep_step),
        .cmd_sweep_count(cmd_sweep_count),
        .abort          (abort),
        .FreqPhase      (FreqPhase),
        .LoadF          (LoadF),
        .LoadP          (LoadP),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [DW-1:0] fp, input logic lf,
                               input logic lp, input logic bz, input logic dn, input logic rdy);
        chk({tag, ".FreqPhase"}, 32'(FreqPhase), 32'(fp));
        chk({tag, ".LoadF"},     32'(LoadF),     32'(lf));
        chk({tag, ".LoadP"},     32'(LoadP),     32'(lp));
        chk({tag, ".busy"},      32'(busy),      32'(bz));
        chk({tag, ".done"},      32'(done),      32'(dn));
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy));
    endtask

    task automatic garbage_inputs(input logic v);
        cmd_valid       = v;
        cmd_mode        = 2'($urandom_range(0, 3));
        cmd_freq        = DW'($urandom);
        cmd_phase       = DW'($urandom);
        cmd_sweep_step  = DW'($urandom);
        cmd_sweep_count = CWID'($urandom);
    endtask

    // Entered and left on a falling edge with the DUT idle; abort_at = 0 means no abort.
    task automatic run_cmd(input string tag, input logic [1:0] mode, input logic [DW-1:0] f,
                           input logic [DW-1:0] p, input logic [DW-1:0] s,
                           input logic [CWID-1:0] c, input int unsigned abort_at);
        logic [DW-1:0] words[$];
        bit            is_p[$];
        int unsigned   n, total, w, pos;
        logic [DW-1:0] e_fp;
        logic          e_lf, e_lp, e_dn, strobe;

        case (mode)
            2'b00: begin words.push_back(f); is_p.push_back(1'b0); end
            2'b01: begin words.push_back(p); is_p.push_back(1'b1); end
            2'b10: begin
                words.push_back(f); is_p.push_back(1'b0);
                words.push_back(p); is_p.push_back(1'b1);
            end
            default: begin
`ifdef DDS_SWEEP_EN
                for (int unsigned i = 0; i <= 32'(c); i++) begin
                    words.push_back(DW'(32'(f) + i * 32'(s)));
                    is_p.push_back(1'b0);
                end
`else
                words.push_back(f); is_p.push_back(1'b0);
                words.push_back(p); is_p.push_back(1'b1);
`endif
            end
        endcase
        n     = words.size();
        total = n * W;

        chk({tag, ".ready_at_accept"}, 32'(cmd_ready), 32'd1);
        cmd_valid       = 1'b1;
        cmd_mode        = mode;
        cmd_freq        = f;
        cmd_phase       = p;
        cmd_sweep_step  = s;
        cmd_sweep_count = c;

        for (int unsigned k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            if (k <= total) begin
                w      = (k - 1) / W;
                pos    = (k - 1) % W;
                strobe = (pos >= HOLD) && (pos < HOLD + PULSE);
                e_fp   = words[w];
                e_lf   = strobe && !is_p[w];
                e_lp   = strobe && is_p[w];
                e_dn   = 1'b0;
            end else begin
                e_fp = words[n-1];
                e_lf = 1'b0;
                e_lp = 1'b0;
                e_dn = 1'b1;
            end
            check_cycle(tag, e_fp, e_lf, e_lp, 1'b1, e_dn, 1'b0);
            last_fp = e_fp;
            if (k == abort_at) begin
                abort     = 1'b1;
                cmd_valid = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                #1;
                check_cycle({tag, ".after_abort"}, last_fp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            // Inputs change freely while busy; only the values captured at acceptance matter.
            if (k <= total) garbage_inputs(1'($urandom_range(0, 1)));
            else cmd_valid = 1'b0;
        end
        @(negedge clk);
        check_cycle({tag, ".idle"}, last_fp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      m;
        logic [DW-1:0]   f, p, s;
        logic [CWID-1:0] c;
        int unsigned     ab;

        rst       = 1'b0;
        abort     = 1'b0;
        garbage_inputs(1'b0);
        repeat (3) @(negedge clk);
        chk("reset.FreqPhase", 32'(FreqPhase), 32'd0);
        chk("reset.LoadF",     32'(LoadF),     32'd0);
        chk("reset.LoadP",     32'(LoadP),     32'd0);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.done",      32'(done),      32'd0);
        rst = 1'b1;
        #1;
        chk("reset.ready_after_release", 32'(cmd_ready), 32'd1);
        last_fp = '0;
        @(negedge clk);

        run_cmd("freq_only", 2'b00, 16'h1234, 16'h5555, 16'h0001, 8'd0, 0);
        run_cmd("freq_phase", 2'b10, 16'h0100, 16'h8000, 16'h0001, 8'd0, 0);
        run_cmd("abort_pulse", 2'b00, 16'h1234, 16'h0000, 16'h0000, 8'd0, 3);
        run_cmd("after_abort", 2'b01, 16'hAAAA, 16'h4321, 16'h0000, 8'd0, 0);
        run_cmd("sweep_wrap", 2'b11, 16'hFFF0, 16'h7777, 16'h0010, 8'd3, 0);
        run_cmd("sweep_zero", 2'b11, 16'h0F0F, 16'h1111, 16'h0100, 8'd0, 0);

        // Abort while idle only blocks acceptance.
        garbage_inputs(1'b1);
        abort = 1'b1;
        #1;
        chk("idle_abort.cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1;
        chk("idle_abort.busy",      32'(busy),      32'd0);
        chk("idle_abort.FreqPhase", 32'(FreqPhase), 32'(last_fp));
        @(negedge clk);

        // Asynchronous reset in the middle of a LoadF pulse.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b00;
        cmd_freq  = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.LoadF_before", 32'(LoadF), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid.LoadF",     32'(LoadF),     32'd0);
        chk("rst_mid.FreqPhase", 32'(FreqPhase), 32'd0);
        chk("rst_mid.busy",      32'(busy),      32'd0);
        chk("rst_mid.done",      32'(done),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid.ready", 32'(cmd_ready), 32'd1);
        last_fp = '0;
        @(negedge clk);

        for (int unsigned i = 0; i < 30; i++) begin
            m  = 2'($urandom_range(0, 3));
            f  = DW'($urandom);
            p  = DW'($urandom);
            s  = DW'($urandom);
            c  = CWID'($urandom_range(0, 5));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            run_cmd("random", m, f, p, s, c, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dds_load_sequencer.md
# dds_load_sequencer

Command-driven initiator for the DDS tuning bus. It accepts frequency/phase update commands over a valid/ready handshake. For each command it drives the shared `FreqPhase` word and generates the `LoadF`/`LoadP` pulses the DDS core expects: data stable before the rising edge, a full high pulse, and data held past the falling edge. It sits between the user-project control logic (Wishbone/LA registers) and the DDS module, so control logic never hand-times load pulses.

## Interface
- `DATA_WIDTH`, 16, width of the frequency/phase word and of the sweep step.
- `HOLD_CYCLES`, 2, cycles `FreqPhase` is stable before the load rises and after it falls; legal range ≥1.
- `PULSE_CYCLES`, 2, cycles a load pulse is high; legal range ≥1.
- `COUNT_WIDTH`, 8, width of `cmd_sweep_count`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_mode` in 2: command type. 00 = frequency only; 01 = phase only; 10 = frequency then phase; 11 = sweep.
- `cmd_freq` in DATA_WIDTH: frequency word.
- `cmd_phase` in DATA_WIDTH: phase word.
- `cmd_sweep_step` in DATA_WIDTH: sweep increment.
- `cmd_sweep_count` in COUNT_WIDTH: number of extra sweep steps.
- `abort` in 1: cancel the current command.
- `FreqPhase` out DATA_WIDTH: bus to the DDS.
- `LoadF` out 1: frequency load strobe.
- `LoadP` out 1: phase load strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes normally.

## Operation
- **Command capture.** The command fields are registered at acceptance. The inputs are don't-care afterwards.
- **Per-word sequence.** Each word goes through three phases:
  - SETUP: `FreqPhase` = word, strobe 0, for HOLD_CYCLES.
  - PULSE: strobe 1, for PULSE_CYCLES.
  - RELEASE: strobe 0, `FreqPhase` unchanged, for HOLD_CYCLES.
- **Strobe selection.** `LoadF` for frequency words, `LoadP` for phase words. The two strobes are never high together.
- **FSM states.** IDLE, SETUP, PULSE, RELEASE, DONE.
  - IDLE → SETUP on accept.
  - SETUP → PULSE → RELEASE on count expiry.
  - RELEASE → SETUP if words remain, else → DONE.
  - DONE → IDLE after one cycle. `done` = 1 in DONE only.
- **Word order.**
  - Mode 00: freq.
  - Mode 01: phase.
  - Mode 10: freq, then phase.
- **`cmd_ready`** = (state == IDLE) & ~abort.
- **`FreqPhase` after completion.** It holds the last driven word and does not return to 0.
- **Abort.**
  - In any non-IDLE state: next state is IDLE and strobes drop to 0 on the next edge. A high pulse is truncated.
  - No `done` is generated. `FreqPhase` holds.
  - In IDLE: abort only blocks acceptance.
- **Reset.**
  - Asynchronous: `FreqPhase` = 0, `LoadF` = `LoadP` = 0, `busy` = 0, `done` = 0. The state goes to IDLE, so `cmd_ready` = 1 once `rst` is high.
  - Asserting reset mid-pulse truncates the pulse immediately.
- **Arithmetic.** Sweep frequency is added modulo 2^DATA_WIDTH; overflow wraps silently.

## Timing
- **Acceptance edge.** Accept at edge t. SETUP starts at t+1, and `FreqPhase` holds the word from t+1.
- **Strobe timing.** Strobe rises at t+1+HOLD_CYCLES and falls at t+1+HOLD_CYCLES+PULSE_CYCLES.
- **Cycle counts.**
  - Per-word cost W = 2·HOLD_CYCLES + PULSE_CYCLES.
  - `done` is high at t+1+n·W, where n = words in the command.
  - `cmd_ready` is high again at t+2+n·W.
- **Back-to-back words.** The next word appears on `FreqPhase` in the cycle after the previous RELEASE ends. There is no extra gap.
- **Throughput.** Maximum command rate is one command per n·W+2 cycles.

## Configuration
- Macro: `DDS_SWEEP_EN`.
- **With the macro defined**, mode 11 is a sweep:
  - Load freq = `cmd_freq`, then `cmd_sweep_count` further frequency loads.
  - Each further load is the previous word + `cmd_sweep_step`.
  - There are `cmd_sweep_count`+1 `LoadF` pulses in total and no `LoadP`.
  - Count 0 behaves exactly like mode 00.
- **Without the macro**, mode 11 behaves exactly as mode 10. The sweep adder, step register and sweep counter are absent, and `cmd_sweep_step`/`cmd_sweep_count` are unused.

## Structure
- **Shared package `dds_ctrl_pkg`.**
  - Mode encodings: `MODE_FREQ`, `MODE_PHASE`, `MODE_BOTH`, `MODE_SWEEP`.
  - FSM state typedef.
  - Strobe-select typedef (F/P).
- **Sub-module `dds_load_pulse`.** Single-word SETUP/PULSE/RELEASE timer with `start`, `sel`, `word` inputs and a `last` output. The top-level FSM owns command decode, word sequencing, sweep arithmetic and abort.

## Test plan
Parameters are HOLD_CYCLES=2, PULSE_CYCLES=2 (W=6) unless stated.

1. Mode 00, freq 0x1234, accept at t.
   - `FreqPhase` = 0x1234 from t+1.
   - `LoadF` high at t+3..t+4 only.
   - `done` at t+7; `cmd_ready` at t+8.
   - `LoadP` never high.
2. Mode 10, freq 0x0100, phase 0x8000.
   - `LoadF` high t+3..t+4; `FreqPhase` = 0x8000 at t+7.
   - `LoadP` high t+9..t+10.
   - `done` at t+13.
   - Strobes never overlap.
3. Abort during the first `LoadF` high cycle (t+3).
   - `LoadF` = 0 at t+4 and `busy` = 0 at t+4.
   - No `done`; `FreqPhase` holds 0x1234.
   - A new command is accepted immediately after.
4. `rst` low asynchronously at t+4 (mid-pulse).
   - `LoadF`, `FreqPhase`, `busy` go to 0 immediately.
   - After release, `cmd_ready` = 1.
5. `DDS_SWEEP_EN` defined; mode 11, freq 0xFFF0, step 0x0010, count 3.
   - Four `LoadF` pulses with words 0xFFF0, 0x0000, 0x0010, 0x0020.
   - `done` at t+25.
   - The same stimulus without the macro gives one `LoadF` (0xFFF0) and one `LoadP`.
6. `cmd_valid` held high with a second command during busy.
   - Not accepted until `cmd_ready`.
   - Fields sampled at acceptance only; changing inputs mid-command has no effect.
